// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and elaboration helpers for the parametrised 1RW SRAM model.
//   sram_state_e : power-up state of the wrapper (zero-fill sweep vs. usable)
//   addr_width() : word-address width, never narrower than one bit
//   lane_count() : number of write-mask lanes per word
//   gran_ok()    : word width is a whole number of mask lanes
//   latency_ok() : read pipeline depth is one of the supported values
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_e;

    function automatic int addr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int lane_count(input int width, input int gran);
        return width / gran;
    endfunction

    function automatic bit gran_ok(input int width, input int gran);
        return (gran > 0) && ((width % gran) == 0);
    endfunction

    function automatic bit latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/sram_1rw_core.sv
// -----------------------------------------------------------------------------
// sram_1rw_core
// Raw single-port storage array with lane-masked writes and a registered read.
// This is the module a physical macro replaces.
//   clk_i   : clock
//   en_i    : access enable for this cycle
//   wmode_i : 1 = write, 0 = read
//   addr_i  : word address; addresses >= DEPTH write nothing and read zero
//   wdata_i : write data
//   wmask_i : per-lane write enable
//   rdata_o : read data, updated only on the edge that performs a read
// -----------------------------------------------------------------------------
module sram_1rw_core
    import sram_pkg::*;
#(
    parameter  int DEPTH     = 2048,
    parameter  int WIDTH     = 36,
    parameter  int MASK_GRAN = 9,
    localparam int AW        = addr_width(DEPTH),
    localparam int LANES     = lane_count(WIDTH, MASK_GRAN)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             wmode_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [LANES-1:0] wmask_i,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int              AW1     = AW + 1;
    // One extra bit so a power-of-two DEPTH is still representable.
    localparam logic [AW1-1:0] DEPTH_L = AW1'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic             in_range;

    assign in_range = ({1'b0, addr_i} < DEPTH_L);

    always_ff @(posedge clk_i) begin
        if (en_i && wmode_i && in_range) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask_i[l]) begin
                    mem_q[addr_i][l*MASK_GRAN +: MASK_GRAN] <= wdata_i[l*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i && !wmode_i) begin
            rdata_q <= in_range ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_1rw_init_pipe.sv
// -----------------------------------------------------------------------------
// sram_1rw_init_pipe
// Parametrised 1RW SRAM behavioural macro with a valid/ready request port,
// lane write mask, 1- or 2-cycle read pipeline and a zero-fill sweep after
// reset (fill pattern INIT_VALUE).
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high
//   req_valid  : request present
//   req_ready  : request accepted when req_valid & req_ready (state only)
//   req_write  : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   req_wmask  : per-lane write enable, lane i = wdata[i*MASK_GRAN +: MASK_GRAN]
//   resp_valid : one-cycle strobe, READ_LATENCY cycles after a read is accepted
//   resp_rdata : read data, holds the last returned word between strobes
//   init_done  : sweep finished, memory usable
// -----------------------------------------------------------------------------
module sram_1rw_init_pipe
    import sram_pkg::*;
#(
    parameter  int               DEPTH         = 2048,
    parameter  int               WIDTH         = 36,
    parameter  int               MASK_GRAN     = 9,
    parameter  int               READ_LATENCY  = 1,
    parameter  bit               INIT_ON_RESET = 1'b1,
    parameter  logic [WIDTH-1:0] INIT_VALUE    = '0,
    localparam int               AW            = addr_width(DEPTH),
    localparam int               LANES         = lane_count(WIDTH, MASK_GRAN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [LANES-1:0] req_wmask,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             init_done
);

    if (!gran_ok(WIDTH, MASK_GRAN)) begin : g_bad_gran
        $error("sram_1rw_init_pipe: WIDTH must be a multiple of MASK_GRAN");
    end
    if (!latency_ok(READ_LATENCY)) begin : g_bad_lat
        $error("sram_1rw_init_pipe: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sram_1rw_init_pipe: DEPTH must be at least 2");
    end

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    sram_state_e      state_q;
    logic [AW-1:0]    cnt_q;
    logic             init_done_q;

    logic             sweep;
    logic             accept;
    logic             core_en;
    logic             core_wmode;
    logic [AW-1:0]    core_addr;
    logic [WIDTH-1:0] core_wdata;
    logic [LANES-1:0] core_wmask;
    logic [WIDTH-1:0] core_rdata;
    logic             vld_p0;

    // Power-up FSM: sweep one word per cycle, then stay READY until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= INIT_ON_RESET ? INIT : READY;
            cnt_q       <= '0;
            init_done_q <= !INIT_ON_RESET;
        end else if (state_q == INIT) begin
            if (cnt_q == LAST) begin
                state_q     <= READY;
                init_done_q <= 1'b1;
                cnt_q       <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign req_ready = (state_q == READY);
    assign init_done = init_done_q;

    // Nothing reaches the array while reset is held, so a request offered
    // alongside reset can neither write nor start a read.
    assign sweep  = (state_q == INIT) && !reset;
    assign accept = req_valid && req_ready && !reset;

    always_comb begin
        core_en    = sweep || accept;
        core_wmode = req_write;
        core_addr  = req_addr;
        core_wdata = req_wdata;
        core_wmask = req_wmask;
        if (sweep) begin
            core_wmode = 1'b1;
            core_addr  = cnt_q;
            core_wdata = INIT_VALUE;
            core_wmask = '1;
        end
    end

    sram_1rw_core #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .MASK_GRAN (MASK_GRAN)
    ) u_core (
        .clk_i   (clock),
        .en_i    (core_en),
        .wmode_i (core_wmode),
        .addr_i  (core_addr),
        .wdata_i (core_wdata),
        .wmask_i (core_wmask),
        .rdata_o (core_rdata)
    );

    // Stage p0: array read register; vld_p0 marks a fresh word in core_rdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept && !req_write;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic             vld_p1;
        logic [WIDTH-1:0] rdata_p1;

        // Stage p1: output register; only loads on a returned word, so it
        // doubles as the hold register.
        always_ff @(posedge clock) begin
            if (reset) begin
                vld_p1   <= 1'b0;
                rdata_p1 <= '0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    rdata_p1 <= core_rdata;
                end
            end
        end

        assign resp_valid = vld_p1;
        assign resp_rdata = rdata_p1;
    end else begin : g_lat1
        logic [WIDTH-1:0] hold_q;

        // Core output passes straight through on the strobe cycle; the hold
        // register keeps it (never X) afterwards.
        always_ff @(posedge clock) begin
            if (reset) begin
                hold_q <= '0;
            end else if (vld_p0) begin
                hold_q <= core_rdata;
            end
        end

        assign resp_valid = vld_p0;
        assign resp_rdata = vld_p0 ? core_rdata : hold_q;
    end

endmodule

// File: tb/tb_sram_1rw_init_pipe.sv
module tb_sram_1rw_init_pipe;

    localparam int NI = 4;

    // Instance set: 0 = small sweep (L1), 1 = 128 deep (L2),
    // 2 = 128 deep, no sweep (L1), 3 = non-power-of-two depth 20 (L1).
    int          dep_m  [NI] = '{16, 128, 128, 20};
    int          lat_m  [NI] = '{1, 2, 1, 1};
    logic [35:0] iv_m   [NI] = '{36'hA5A5A5A5A, 36'h0, 36'h0, 36'h5A5A5A5A5};

    logic            clk = 1'b0;
    logic [NI-1:0]   rst = '1;
    logic [NI-1:0]   vld = '0;
    logic            wr = 1'b0;
    logic [6:0]      addr = '0;
    logic [35:0]     wdata = '0;
    logic [3:0]      wmask = '0;
    wire  [NI-1:0]   rdy, rv, idone;
    wire  [35:0]     rd [NI];

    logic [35:0]     mdl [NI][128];
    int              n_cmp = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    sram_1rw_init_pipe #(.DEPTH(16), .WIDTH(36), .MASK_GRAN(9), .READ_LATENCY(1),
        .INIT_ON_RESET(1), .INIT_VALUE(36'hA5A5A5A5A)) u_d0 (
        .clock(clk), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_write(wr), .req_addr(addr[3:0]), .req_wdata(wdata), .req_wmask(wmask),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .init_done(idone[0]));

    sram_1rw_init_pipe #(.DEPTH(128), .WIDTH(36), .MASK_GRAN(9), .READ_LATENCY(2),
        .INIT_ON_RESET(1), .INIT_VALUE(36'h0)) u_d1 (
        .clock(clk), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_write(wr), .req_addr(addr[6:0]), .req_wdata(wdata), .req_wmask(wmask),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .init_done(idone[1]));

    sram_1rw_init_pipe #(.DEPTH(128), .WIDTH(36), .MASK_GRAN(9), .READ_LATENCY(1),
        .INIT_ON_RESET(0), .INIT_VALUE(36'h0)) u_d2 (
        .clock(clk), .reset(rst[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_write(wr), .req_addr(addr[6:0]), .req_wdata(wdata), .req_wmask(wmask),
        .resp_valid(rv[2]), .resp_rdata(rd[2]), .init_done(idone[2]));

    sram_1rw_init_pipe #(.DEPTH(20), .WIDTH(36), .MASK_GRAN(9), .READ_LATENCY(1),
        .INIT_ON_RESET(1), .INIT_VALUE(36'h5A5A5A5A5)) u_d3 (
        .clock(clk), .reset(rst[3]), .req_valid(vld[3]), .req_ready(rdy[3]),
        .req_write(wr), .req_addr(addr[4:0]), .req_wdata(wdata), .req_wmask(wmask),
        .resp_valid(rv[3]), .resp_rdata(rd[3]), .init_done(idone[3]));

    // ---------------- reference model ----------------
    function automatic logic [35:0] lane_bits(input logic [3:0] m);
        logic [35:0] r = '0;
        for (int l = 0; l < 4; l++) if (m[l]) r[l*9 +: 9] = 9'h1FF;
        return r;
    endfunction

    function automatic logic [35:0] mdl_read(input int i, input int a);
        return (a < dep_m[i]) ? mdl[i][a] : 36'h0;
    endfunction

    task automatic mdl_write(input int i, input int a, input logic [35:0] d, input logic [3:0] m);
        if (a < dep_m[i]) mdl[i][a] = (mdl[i][a] & ~lane_bits(m)) | (d & lane_bits(m));
    endtask

    task automatic mdl_fill(input int i);
        for (int a = 0; a < dep_m[i]; a++) mdl[i][a] = iv_m[i];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input bit w, input int a, input logic [35:0] d, input logic [3:0] m);
        wr = w; addr = 7'(a); wdata = d; wmask = m; vld[i] = 1'b1;
        if (w) mdl_write(i, a, d, m);
        tick();
        vld[i] = 1'b0;
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!idone[i] && n < 400) begin tick(); n++; end
        n_cmp++;
        if (idone[i] !== 1'b1) begin
            n_err++; $display("FAIL wait_ready[%0d]: init_done=%b required 1 within 400 cycles", i, idone[i]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = '1; vld = '0;
        tick(); tick(); tick();
        for (int i = 0; i < NI; i++) begin
            n_cmp += 4;
            if (rv[i] !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid[%0d]: got %b want 0", i, rv[i]); end
            if (rd[i] !== 36'h0) begin n_err++; $display("FAIL reset_resp_rdata[%0d]: got %h want 0", i, rd[i]); end
            if (idone[i] !== (i == 2)) begin n_err++; $display("FAIL reset_init_done[%0d]: got %b want %b", i, idone[i], (i == 2)); end
            if (rdy[i] !== (i == 2)) begin n_err++; $display("FAIL reset_req_ready[%0d]: got %b want %b", i, rdy[i], (i == 2)); end
        end
        rst = '0;
        for (int i = 0; i < NI; i++) if (i != 2) mdl_fill(i);
    endtask

    task automatic test_init_sweep();
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (idone[0] !== 1'b0 || rdy[0] !== 1'b0) begin
                n_err++; $display("FAIL sweep_busy cycle %0d: init_done=%b req_ready=%b want 0/0", k, idone[0], rdy[0]);
            end
            tick();
        end
        n_cmp++;
        if (idone[0] !== 1'b1 || rdy[0] !== 1'b1) begin
            n_err++; $display("FAIL sweep_done: init_done=%b req_ready=%b want 1/1", idone[0], rdy[0]);
        end
        wr = 1'b0; wdata = '0; wmask = '0;
        for (int a = 0; a < 16; a++) begin
            addr = 7'(a); vld[0] = 1'b1;
            tick();
            n_cmp++;
            if (rv[0] !== 1'b1 || rd[0] !== 36'hA5A5A5A5A) begin
                n_err++; $display("FAIL sweep_read addr %0d: valid=%b data=%h want 1/%h", a, rv[0], rd[0], 36'hA5A5A5A5A);
            end
        end
        vld[0] = 1'b0;
    endtask

    task automatic test_mid_sweep_reset();
        int n = 0;
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        repeat (7) tick();
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        while (!idone[0] && n < 40) begin tick(); n++; end
        n_cmp++;
        if (n !== 16) begin n_err++; $display("FAIL mid_sweep_restart: init_done after %0d cycles want 16", n); end
        req(0, 0, 15, '0, '0);
        n_cmp++;
        if (rv[0] !== 1'b1 || rd[0] !== iv_m[0]) begin
            n_err++; $display("FAIL mid_sweep_read15: valid=%b data=%h want 1/%h", rv[0], rd[0], iv_m[0]);
        end
    endtask

    task automatic test_masked_write();
        for (int i = 1; i <= 2; i++) begin
            wait_ready(i);
            req(i, 1, 5, 36'hFFFFFFFFF, 4'b1111);
            req(i, 1, 5, 36'h0, 4'b0101);
            req(i, 0, 5, '0, '0);
            if (lat_m[i] == 2) tick();
            n_cmp++;
            if (rv[i] !== 1'b1 || rd[i] !== 36'hFF803FE00) begin
                n_err++; $display("FAIL masked_write[%0d]: valid=%b data=%h want 1/%h", i, rv[i], rd[i], 36'hFF803FE00);
            end
            // all-zero mask leaves the word alone
            req(i, 1, 5, 36'h123123123, 4'b0000);
            req(i, 0, 5, '0, '0);
            if (lat_m[i] == 2) tick();
            n_cmp++;
            if (rd[i] !== 36'hFF803FE00) begin
                n_err++; $display("FAIL zero_mask[%0d]: data=%h want %h", i, rd[i], 36'hFF803FE00);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] e [3];
        wait_ready(1);
        for (int a = 1; a <= 3; a++) req(1, 1, a, {4'($urandom), $urandom}, 4'hF);
        for (int a = 1; a <= 3; a++) e[a-1] = mdl_read(1, a);
        wr = 1'b0;
        addr = 7'd1; vld[1] = 1'b1; tick();
        n_cmp++;
        if (rv[1] !== 1'b0) begin n_err++; $display("FAIL b2b_early: valid=%b want 0 at +1", rv[1]); end
        addr = 7'd2; tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) addr = 7'd3;
            if (k == 1) vld[1] = 1'b0;
            n_cmp++;
            if (rv[1] !== 1'b1 || rd[1] !== e[k]) begin
                n_err++; $display("FAIL b2b_resp %0d: valid=%b data=%h want 1/%h", k, rv[1], rd[1], e[k]);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rv[1] !== 1'b0 || rd[1] !== e[2]) begin
                n_err++; $display("FAIL b2b_hold %0d: valid=%b data=%h want 0/%h", k, rv[1], rd[1], e[2]);
            end
            tick();
        end
    endtask

    task automatic test_write_then_read();
        for (int i = 1; i <= 2; i++) begin
            req(i, 1, 100, 36'h123456789, 4'hF);
            req(i, 0, 100, '0, '0);
            if (lat_m[i] == 2) tick();
            n_cmp++;
            if (rv[i] !== 1'b1 || rd[i] !== 36'h123456789) begin
                n_err++; $display("FAIL wr_then_rd[%0d]: valid=%b data=%h want 1/%h", i, rv[i], rd[i], 36'h123456789);
            end
            tick();
            n_cmp++;
            if (rv[i] !== 1'b0) begin n_err++; $display("FAIL wr_then_rd_pulse[%0d]: valid=%b want 0", i, rv[i]); end
        end
    endtask

    task automatic test_out_of_range();
        wait_ready(3);
        req(3, 0, 19, '0, '0);
        n_cmp++;
        if (rv[3] !== 1'b1 || rd[3] !== iv_m[3]) begin
            n_err++; $display("FAIL oor_pre19: valid=%b data=%h want 1/%h", rv[3], rd[3], iv_m[3]);
        end
        req(3, 1, 25, 36'hDEADBEEF1, 4'hF);
        req(3, 0, 25, '0, '0);
        n_cmp++;
        if (rv[3] !== 1'b1 || rd[3] !== 36'h0) begin
            n_err++; $display("FAIL oor_read25: valid=%b data=%h want 1/0", rv[3], rd[3]);
        end
        tick();
        n_cmp++;
        if (rv[3] !== 1'b0 || rd[3] !== 36'h0) begin
            n_err++; $display("FAIL oor_pulse: valid=%b data=%h want 0/0", rv[3], rd[3]);
        end
        req(3, 0, 19, '0, '0);
        n_cmp++;
        if (rv[3] !== 1'b1 || rd[3] !== mdl_read(3, 19)) begin
            n_err++; $display("FAIL oor_addr19: valid=%b data=%h want 1/%h", rv[3], rd[3], mdl_read(3, 19));
        end
    endtask

    task automatic test_reset_inflight();
        // L2: reset on the edge after accept drops the read
        req(1, 0, 5, '0, '0);
        rst[1] = 1'b1; tick();
        n_cmp++;
        if (rv[1] !== 1'b0 || rd[1] !== 36'h0) begin
            n_err++; $display("FAIL inflight_l2: valid=%b data=%h want 0/0", rv[1], rd[1]);
        end
        tick();
        n_cmp++;
        if (rv[1] !== 1'b0) begin n_err++; $display("FAIL inflight_l2_late: valid=%b want 0", rv[1]); end
        rst[1] = 1'b0; mdl_fill(1);
        // requests offered mid-sweep are ignored
        repeat (20) tick();
        n_cmp++;
        if (rdy[1] !== 1'b0) begin n_err++; $display("FAIL init_ready: req_ready=%b want 0", rdy[1]); end
        wr = 1'b1; addr = 7'd7; wdata = 36'h777777777; wmask = 4'hF; vld[1] = 1'b1; tick();
        wr = 1'b0; tick(); vld[1] = 1'b0; tick();
        n_cmp++;
        if (rv[1] !== 1'b0) begin n_err++; $display("FAIL init_read_ignored: valid=%b want 0", rv[1]); end
        wait_ready(1);
        req(1, 0, 7, '0, '0); tick();
        n_cmp++;
        if (rv[1] !== 1'b1 || rd[1] !== 36'h0) begin
            n_err++; $display("FAIL init_write_ignored: valid=%b data=%h want 1/0", rv[1], rd[1]);
        end
        // L1: reset on the accept edge itself
        wr = 1'b0; addr = 7'd3; vld[3] = 1'b1; rst[3] = 1'b1; tick();
        vld[3] = 1'b0; rst[3] = 1'b0;
        n_cmp++;
        if (rv[3] !== 1'b0 || rd[3] !== 36'h0) begin
            n_err++; $display("FAIL inflight_l1: valid=%b data=%h want 0/0", rv[3], rd[3]);
        end
        mdl_fill(3);
    endtask

    task automatic test_random(input int i, input int nops);
        logic [35:0] exp_q [$];
        int          due_q [$];
        logic [35:0] hold = '0;
        bit          have = 1'b0;
        bit          ev;
        int          a;
        wait_ready(i);
        for (int c = 0; c < nops + 4; c++) begin
            ev = (due_q.size() > 0) && (due_q[0] == c);
            if (ev) begin hold = exp_q.pop_front(); void'(due_q.pop_front()); have = 1'b1; end
            n_cmp++;
            if (rv[i] !== ev || (have && rd[i] !== hold)) begin
                n_err++; $display("FAIL random[%0d] cycle %0d: valid=%b data=%h want %b/%h", i, c, rv[i], rd[i], ev, hold);
            end
            if (c < nops && $urandom_range(0, 3) != 0) begin
                a = $urandom_range(0, (i == 3) ? 31 : 127);
                wr = 1'($urandom); addr = 7'(a); wdata = {4'($urandom), $urandom}; wmask = 4'($urandom);
                vld[i] = 1'b1;
                if (wr) mdl_write(i, a, wdata, wmask);
                else begin exp_q.push_back(mdl_read(i, a)); due_q.push_back(c + lat_m[i]); end
            end else begin
                vld[i] = 1'b0;
            end
            tick();
        end
        vld[i] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_mid_sweep_reset();
        test_masked_write();
        test_back_to_back();
        test_write_then_read();
        test_out_of_range();
        test_reset_inflight();
        test_random(1, 300);
        test_random(3, 300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
